// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the two-requester I2C master arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2c_arb_pkg;

  localparam int NUM_REQ            = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RELEASE   = 3'd5
  } arb_state_t;

  // Requester index to one-hot lane for a two-way arbiter.
  function automatic logic [NUM_REQ-1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/i2c_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: favours the requester not served last.
// Latency: purely combinational.
// Backpressure: none; the caller only consumes the pick while idle.
module rr_arbiter2
  import i2c_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic               pick_vld,
  output logic               pick_idx
);

  // A lone request wins outright; a tie goes to the requester not served last.
  always_comb begin
    pick_vld = |req;
    pick_idx = 1'b0;
    if (req == 2'b11) pick_idx = ~last;
    else              pick_idx = req[1];
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates two requesters onto one I2C master; optional watchdog under I2C_ARB_TIMEOUT_EN.
// Latency: start pulse 2 cycles after req is sampled in idle; done 1 cycle after m_done.
// Backpressure: requesters hold req until granted; at most one transaction is in flight.
module i2c_arbiter #(
  parameter int TIMEOUT_CYCLES = i2c_arb_pkg::DEF_TIMEOUT_CYCLES,
  parameter int NUM_REQ        = i2c_arb_pkg::NUM_REQ
) (
  input  logic                    clk_400,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_rw,
  input  logic [NUM_REQ-1:0][6:0] req_addr,
  input  logic [NUM_REQ-1:0][7:0] req_wdata,
  input  logic [NUM_REQ-1:0]      req_more,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      err,
  output logic [7:0]              rdata,
  output logic                    m_rw,
  output logic                    m_start_txn,
  output logic                    m_next_byte,
  output logic [6:0]              m_sub_addr,
  output logic [7:0]              m_data_in,
  input  logic                    m_busy,
  input  logic                    m_done,
  input  logic                    m_ack_error,
  input  logic [7:0]              m_data_out
);

  i2c_arb_pkg::arb_state_t state_q, state_d;

  logic owner_q;     // requester owning the master
  logic last_q;      // requester served most recently
  logic pick_vld;
  logic pick_idx;
  logic in_wait;     // master transaction is in progress
  logic cap_vld;     // master finished this cycle
  logic to_hit;      // watchdog expired this cycle

  rr_arbiter2 u_rr (
    .req      (req),
    .last     (last_q),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

  assign in_wait = (state_q == i2c_arb_pkg::ST_WAIT_BUSY) ||
                   (state_q == i2c_arb_pkg::ST_WAIT_DONE);
  assign cap_vld = in_wait && m_done;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;

  // Watchdog counts from the start pulse; cleared while granting.
  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == i2c_arb_pkg::ST_GRANT) begin
      to_cnt_q <= '0;
    end else if (in_wait || (state_q == i2c_arb_pkg::ST_LAUNCH)) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign to_hit = in_wait && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Next-state decode; a real m_done always takes precedence over the watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      i2c_arb_pkg::ST_IDLE:      if (pick_vld) state_d = i2c_arb_pkg::ST_GRANT;
      i2c_arb_pkg::ST_GRANT:     state_d = i2c_arb_pkg::ST_LAUNCH;
      i2c_arb_pkg::ST_LAUNCH:    state_d = i2c_arb_pkg::ST_WAIT_BUSY;
      i2c_arb_pkg::ST_WAIT_BUSY: begin
        if (m_done || to_hit) state_d = i2c_arb_pkg::ST_RELEASE;
        else if (m_busy)      state_d = i2c_arb_pkg::ST_WAIT_DONE;
      end
      i2c_arb_pkg::ST_WAIT_DONE: if (m_done || to_hit) state_d = i2c_arb_pkg::ST_RELEASE;
      i2c_arb_pkg::ST_RELEASE:   state_d = i2c_arb_pkg::ST_IDLE;
      default:                   state_d = i2c_arb_pkg::ST_IDLE;
    endcase
  end

  // State, ownership, grant and the one-cycle start pulse.
  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) begin
      state_q     <= i2c_arb_pkg::ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      gnt         <= '0;
      m_start_txn <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_start_txn <= (state_q == i2c_arb_pkg::ST_GRANT);
      if (state_q == i2c_arb_pkg::ST_IDLE && pick_vld) begin
        owner_q <= pick_idx;
        gnt     <= i2c_arb_pkg::idx2oh(pick_idx);
      end
      if (in_wait && state_d == i2c_arb_pkg::ST_RELEASE) gnt <= '0;
      if (state_q == i2c_arb_pkg::ST_RELEASE) last_q <= owner_q;
    end
  end

  // Master operands are snapshotted once and then ignore requester changes.
  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) begin
      m_rw        <= 1'b0;
      m_next_byte <= 1'b0;
      m_sub_addr  <= '0;
      m_data_in   <= '0;
    end else if (state_q == i2c_arb_pkg::ST_GRANT) begin
      m_rw        <= req_rw[owner_q];
      m_next_byte <= req_more[owner_q];
      m_sub_addr  <= req_addr[owner_q];
      m_data_in   <= req_wdata[owner_q];
    end
  end

  // Completion status to the owner; rdata only moves on a finished read.
  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) begin
      done  <= '0;
      err   <= '0;
      rdata <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      if (cap_vld) begin
        done <= i2c_arb_pkg::idx2oh(owner_q);
        err  <= m_ack_error ? i2c_arb_pkg::idx2oh(owner_q) : '0;
        if (m_rw) rdata <= m_data_out;
      end else if (to_hit) begin
        done <= i2c_arb_pkg::idx2oh(owner_q);
        err  <= i2c_arb_pkg::idx2oh(owner_q);
      end
    end
  end

endmodule
